// File: rtl/rtc_pkg.sv
// Shared types, limits and BCD helpers for the time-of-day core.
//   rtc_state_t : set-FSM state, encoded so the value doubles as the field-in-edit code
//   field_sel_t : 0 none, 1 HH, 2 MM, 3 SS
//   bcd2_t      : two-digit packed BCD byte
package rtc_pkg;

    localparam int unsigned HH_MAX = 23;
    localparam int unsigned MS_MAX = 59;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SET_HH = 2'd1,
        SET_MM = 2'd2,
        SET_SS = 2'd3
    } rtc_state_t;

    typedef logic [1:0] field_sel_t;
    typedef logic [7:0] bcd2_t;

    // Two-digit BCD to binary (0..99).
    function automatic logic [6:0] bcd_to_bin(input bcd2_t v);
        return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
    endfunction

    // Binary (0..99) to two-digit BCD.
    function automatic bcd2_t bin_to_bcd(input logic [6:0] b);
        return {4'(b / 7'd10), 4'(b % 7'd10)};
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter (0..MAX) with wrap in both directions.
//   clk_i   : system clock
//   clr_i   : synchronous clear to 00
//   inc_i   : step up (edit)            dec_i : step down (edit)
//   carry_i : step up (cascade from the lower field)
//   value_o : registered value          next_o : value after this cycle
//   carry_o : carry_i while at MAX (feeds the next field up)
module bcd_mod_counter
    import rtc_pkg::*;
#(
    parameter int unsigned MAX = 59
) (
    input  logic  clk_i,
    input  logic  clr_i,
    input  logic  inc_i,
    input  logic  dec_i,
    input  logic  carry_i,
    output bcd2_t value_o,
    output bcd2_t next_o,
    output logic  carry_o
);

    localparam bcd2_t MAX_BCD = bin_to_bcd(7'(MAX));

    bcd2_t value_q, value_d;

    // Next value: up-steps win over down-steps; callers keep them exclusive anyway.
    always_comb begin
        value_d = value_q;
        if (inc_i || carry_i) begin
            if (value_q == MAX_BCD)
                value_d = 8'h00;
            else if (value_q[3:0] == 4'd9)
                value_d = {value_q[7:4] + 4'd1, 4'd0};
            else
                value_d = {value_q[7:4], value_q[3:0] + 4'd1};
        end else if (dec_i) begin
            if (value_q == 8'h00)
                value_d = MAX_BCD;
            else if (value_q[3:0] == 4'd0)
                value_d = {value_q[7:4] - 4'd1, 4'd9};
            else
                value_d = {value_q[7:4], value_q[3:0] - 4'd1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) value_q <= 8'h00;
        else       value_q <= value_d;
    end

    assign value_o = value_q;
    assign next_o  = value_d;
    assign carry_o = carry_i && (value_q == MAX_BCD);

endmodule

// File: rtl/rtc_timekeeper.sv
// Single-clock BCD time-of-day core with button-driven field setting, alarm and edit blink.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   btn_mode/inc/dec_i  : debounced 1-cycle button pulses
//   mode_12h_i          : 1 = 12h display
//   alarm_wr/hh/mm/en_i : alarm load (BCD, 24h) and arm
//   time_bcd_o, pm_o    : display time {HH,MM,SS} and PM flag (combinational map of registers)
//   set_field_o         : field in edit; blink_o : visibility of that field
//   sec_tick_o          : pulse when time_bcd_o first shows a tick-advanced value
//   alarm_hit_o         : pulse on alarm match, coincident with sec_tick_o
module rtc_timekeeper
    import rtc_pkg::*;
#(
    parameter int unsigned F_CLK    = 50_000_000,
    parameter int unsigned F_TICK   = 1,
    parameter int unsigned BLINK_HZ = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        btn_mode_i,
    input  logic        btn_inc_i,
    input  logic        btn_dec_i,
    input  logic        mode_12h_i,
    input  logic        alarm_wr_i,
    input  logic [7:0]  alarm_hh_i,
    input  logic [7:0]  alarm_mm_i,
    input  logic        alarm_en_i,
    output logic [23:0] time_bcd_o,
    output logic        pm_o,
    output field_sel_t  set_field_o,
    output logic        blink_o,
    output logic        sec_tick_o,
    output logic        alarm_hit_o
);

    localparam int unsigned PRE_N = F_CLK / F_TICK;
    localparam int unsigned PRE_W = (PRE_N > 1) ? $clog2(PRE_N) : 1;
    localparam int unsigned BLK_N = F_CLK / (2 * BLINK_HZ);
    localparam int unsigned BLK_W = (BLK_N > 1) ? $clog2(BLK_N) : 1;

    if ((F_CLK % F_TICK) != 0) begin : g_bad_tick
        $error("rtc_timekeeper: F_CLK must be a multiple of F_TICK");
    end
    if ((F_CLK % (2 * BLINK_HZ)) != 0) begin : g_bad_blink
        $error("rtc_timekeeper: F_CLK must be a multiple of 2*BLINK_HZ");
    end

    rtc_state_t       state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
    logic             blink_q, blink_d;
    logic             sec_tick_q;
    logic             alarm_hit_q, alarm_hit_d;
    bcd2_t            al_hh_q, al_hh_d, al_mm_q, al_mm_d;

    logic             tick, inc_acc, dec_acc;
    bcd2_t            hh_q, mm_q, ss_q, hh_nx, mm_nx, ss_nx;
    logic             ss_carry, mm_carry, hh_carry_unused;
    logic [6:0]       hh_bin, hh_disp_bin;
    logic             al_valid;

    assign tick = (state_q == RUN) && (pre_q == PRE_W'(PRE_N - 1));

    // Set FSM: mode button advances and swallows any inc/dec in the same cycle.
    always_comb begin
        state_d = state_q;
        inc_acc = 1'b0;
        dec_acc = 1'b0;
        if (btn_mode_i) begin
            case (state_q)
                RUN:     state_d = SET_HH;
                SET_HH:  state_d = SET_MM;
                SET_MM:  state_d = SET_SS;
                default: state_d = RUN;
            endcase
        end else if (state_q != RUN) begin
            inc_acc = btn_inc_i && !btn_dec_i;
            dec_acc = btn_dec_i && !btn_inc_i;
        end
    end

    bcd_mod_counter #(.MAX(MS_MAX)) u_ss (
        .clk_i   (clk_i),
        .clr_i   (rst_i),
        .inc_i   (inc_acc && (state_q == SET_SS)),
        .dec_i   (dec_acc && (state_q == SET_SS)),
        .carry_i (tick),
        .value_o (ss_q),
        .next_o  (ss_nx),
        .carry_o (ss_carry)
    );

    bcd_mod_counter #(.MAX(MS_MAX)) u_mm (
        .clk_i   (clk_i),
        .clr_i   (rst_i),
        .inc_i   (inc_acc && (state_q == SET_MM)),
        .dec_i   (dec_acc && (state_q == SET_MM)),
        .carry_i (ss_carry),
        .value_o (mm_q),
        .next_o  (mm_nx),
        .carry_o (mm_carry)
    );

    bcd_mod_counter #(.MAX(HH_MAX)) u_hh (
        .clk_i   (clk_i),
        .clr_i   (rst_i),
        .inc_i   (inc_acc && (state_q == SET_HH)),
        .dec_i   (dec_acc && (state_q == SET_HH)),
        .carry_i (mm_carry),
        .value_o (hh_q),
        .next_o  (hh_nx),
        .carry_o (hh_carry_unused)
    );

    assign al_valid = (alarm_hh_i[3:0] <= 4'd9) && (alarm_hh_i <= 8'h23) &&
                      (alarm_mm_i[3:0] <= 4'd9) && (alarm_mm_i <= 8'h59);

    // Prescaler, blink timer and alarm next-state.
    always_comb begin
        pre_d       = pre_q + PRE_W'(1);
        blink_d     = blink_q;
        blk_cnt_d   = blk_cnt_q + BLK_W'(1);
        al_hh_d     = al_hh_q;
        al_mm_d     = al_mm_q;
        alarm_hit_d = 1'b0;

        // Held at 0 outside RUN, so the first tick after setting is a full period away.
        if (state_q != RUN || state_d != RUN || tick)
            pre_d = '0;

        if (state_d == RUN || btn_mode_i || inc_acc || dec_acc) begin
            blink_d   = 1'b1;
            blk_cnt_d = '0;
        end else if (blk_cnt_q == BLK_W'(BLK_N - 1)) begin
            blink_d   = !blink_q;
            blk_cnt_d = '0;
        end

        if (alarm_wr_i && al_valid) begin
            al_hh_d = alarm_hh_i;
            al_mm_d = alarm_mm_i;
        end

        // Match on the post-tick time so the hit lines up with sec_tick.
        alarm_hit_d = tick && alarm_en_i && (hh_nx == al_hh_q) &&
                      (mm_nx == al_mm_q) && (ss_nx == 8'h00);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            pre_q       <= '0;
            blk_cnt_q   <= '0;
            blink_q     <= 1'b1;
            sec_tick_q  <= 1'b0;
            alarm_hit_q <= 1'b0;
            al_hh_q     <= 8'h00;
            al_mm_q     <= 8'h00;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            blk_cnt_q   <= blk_cnt_d;
            blink_q     <= blink_d;
            sec_tick_q  <= tick;
            alarm_hit_q <= alarm_hit_d;
            al_hh_q     <= al_hh_d;
            al_mm_q     <= al_mm_d;
        end
    end

    // 12h display map; internal time stays 24h.
    always_comb begin
        hh_bin      = bcd_to_bin(hh_q);
        hh_disp_bin = hh_bin;
        pm_o        = 1'b0;
        if (mode_12h_i) begin
            pm_o = (hh_bin >= 7'd12);
            if (hh_bin == 7'd0)
                hh_disp_bin = 7'd12;
            else if (hh_bin > 7'd12)
                hh_disp_bin = hh_bin - 7'd12;
        end
    end

    assign time_bcd_o  = {bin_to_bcd(hh_disp_bin), mm_q, ss_q};
    assign set_field_o = field_sel_t'(state_q);
    assign blink_o     = blink_q;
    assign sec_tick_o  = sec_tick_q;
    assign alarm_hit_o = alarm_hit_q;

endmodule
